// File: rtl/gpio_cfg_serializer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Package    : rfsoc_config
// | Description: GPIO line map, FSM state and command-class types for the
// |              GPIO configuration bus serializer.
// | Revision   : 1.0 - initial release
// +-----------------------------------------------------------------------------
package rfsoc_config;

   localparam logic [7:0] c_sdata                   = 8'd0;
   localparam logic [7:0] c_mask_clk                = 8'd1;
   localparam logic [7:0] c_sel_clk                 = 8'd2;
   localparam logic [7:0] c_cycle_count_clk         = 8'd3;
   localparam logic [7:0] c_mux_set_clk             = 8'd4;
   localparam logic [7:0] c_pl_rst                  = 8'd5;
   localparam logic [7:0] c_trigger_line            = 8'd6;
   localparam logic [7:0] c_adc_num_avg_clk         = 8'd7;
   localparam logic [7:0] c_adc_num_cycle_count_clk = 8'd8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_PULSE = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CLS_SHIFT   = 2'd0,
      CLS_PULSE   = 2'd1,
      CLS_ILLEGAL = 2'd2
   } cmd_class_t;

   function automatic cmd_class_t target_class(input logic [7:0] target);
      case (target)
         c_mask_clk, c_sel_clk, c_cycle_count_clk, c_mux_set_clk,
         c_adc_num_avg_clk, c_adc_num_cycle_count_clk: target_class = CLS_SHIFT;
         c_pl_rst, c_trigger_line:                     target_class = CLS_PULSE;
         default:                                      target_class = CLS_ILLEGAL;
      endcase
   endfunction

   // The two ADC count registers share physical bit 7; the downstream mux
   // steers it, so line index 8 drives the same bus bit as index 7.
   function automatic logic [2:0] line_bit(input logic [7:0] target);
      if (target == c_adc_num_cycle_count_clk)
         line_bit = 3'd7;
      else
         line_bit = target[2:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_cfg_serializer_phase_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module     : gpio_phase_timer
// | Description: Reloadable down-counter; a load of N makes expire rise on the
// |              Nth cycle after the load edge.
// | Revision   : 1.0 - initial release
// +-----------------------------------------------------------------------------
module gpio_phase_timer #(
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // load_val is always >= 1, so the reload never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val - CNT_W'(1);
      else if (cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/gpio_cfg_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module     : gpio_cfg_serializer
// | Description: Serializes configuration commands onto the GPIO config bus as
// |              MSB-first shifts or timed pulses. Optional CFG_STATUS_EN adds
// |              xfer_count / err_sticky status outputs.
// | Revision   : 1.0 - initial release
// +-----------------------------------------------------------------------------
module gpio_cfg_serializer
   import rfsoc_config::*;
#(
   parameter int MAX_BITS    = 256,
   parameter int HALF_PERIOD = 2,
   parameter int LEN_W       = $clog2(MAX_BITS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [7:0]          cmd_target,
   input  logic [LEN_W-1:0]    cmd_len,
   input  logic [MAX_BITS-1:0] cmd_data,
   output logic [7:0]          gpio_out,
   output logic                busy,
   output logic                done,
   output logic                err
`ifdef CFG_STATUS_EN
   ,
   output logic [15:0]         xfer_count,
   output logic                err_sticky
`endif
);

   localparam int IDX_W = $clog2(MAX_BITS);
   localparam int HP_W  = $clog2(HALF_PERIOD + 1);
   localparam int TMR_W = (LEN_W > HP_W) ? LEN_W : HP_W;
   localparam logic [TMR_W-1:0] c_half = TMR_W'(HALF_PERIOD);

   state_t              state_q, state_d;
   logic [2:0]          line_q, line_d;
   logic [MAX_BITS-1:0] data_q, data_d;
   logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]          gpio_q, gpio_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                ready_q, ready_d;

   logic                w_accept;
   cmd_class_t          w_class;
   logic [LEN_W-1:0]    w_eff_len;
   logic [TMR_W-1:0]    w_pulse_len;
   logic [IDX_W-1:0]    w_bit_idx;
   logic                w_tmr_load;
   logic [TMR_W-1:0]    w_tmr_val;
   logic                w_tmr_expire;

   assign w_accept    = cmd_valid && ready_q;
   assign w_class     = target_class(cmd_target);
   assign w_eff_len   = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;
   assign w_pulse_len = (cmd_len == '0) ? TMR_W'(1) : TMR_W'(cmd_len);

   gpio_phase_timer #(
      .CNT_W    (TMR_W)
   ) u_phase_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .expire   (w_tmr_expire)
   );

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      data_d     = data_q;
      bit_cnt_d  = bit_cnt_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      w_tmr_load = 1'b0;
      w_tmr_val  = c_half;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               case (w_class)
                  CLS_SHIFT: begin
                     if (cmd_len == '0) begin
                        done_d = 1'b1;
                     end else begin
                        state_d    = ST_SETUP;
                        line_d     = line_bit(cmd_target);
                        data_d     = cmd_data;
                        bit_cnt_d  = w_eff_len;
                        w_tmr_load = 1'b1;
                     end
                  end
                  CLS_PULSE: begin
                     state_d    = ST_PULSE;
                     line_d     = line_bit(cmd_target);
                     w_tmr_load = 1'b1;
                     w_tmr_val  = w_pulse_len;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_SETUP: begin
            if (w_tmr_expire) begin
               state_d    = ST_HIGH;
               w_tmr_load = 1'b1;
            end
         end
         ST_HIGH: begin
            if (w_tmr_expire) begin
               w_tmr_load = 1'b1;
               // bit_cnt stays at 1 through HOLD so sdata keeps the last bit.
               if (bit_cnt_q == LEN_W'(1)) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d   = ST_SETUP;
                  bit_cnt_d = bit_cnt_q - LEN_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (w_tmr_expire) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
               done_d    = 1'b1;
            end
         end
         ST_PULSE: begin
            if (w_tmr_expire) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus outputs are registered from the next state so the lines never glitch.
   assign w_bit_idx = IDX_W'(bit_cnt_d - LEN_W'(1));

   always_comb begin
      gpio_d = '0;
      if (state_d inside {ST_SETUP, ST_HIGH, ST_HOLD})
         gpio_d[0] = data_d[w_bit_idx];
      if (state_d == ST_HIGH || state_d == ST_PULSE)
         gpio_d[line_d] = 1'b1;
      busy_d  = (state_d != ST_IDLE);
      ready_d = !busy_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         line_q    <= '0;
         data_q    <= '0;
         bit_cnt_q <= '0;
         gpio_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         data_q    <= data_d;
         bit_cnt_q <= bit_cnt_d;
         gpio_q    <= gpio_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   assign gpio_out  = gpio_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign cmd_ready = ready_q;

`ifdef CFG_STATUS_EN
   logic [15:0] xfer_count_q, xfer_count_d;
   logic        err_sticky_q, err_sticky_d;

   // Status moves on the same edge that raises done/err.
   always_comb begin
      xfer_count_d = done_d ? (xfer_count_q + 16'd1) : xfer_count_q;
      err_sticky_d = err_sticky_q | err_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_count_q <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         xfer_count_q <= xfer_count_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign xfer_count = xfer_count_q;
   assign err_sticky = err_sticky_q;
`endif

endmodule
`default_nettype wire
